// File: rtl/wb_serial_master_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_serial_master_if
// Description : Bundles the byte-stream and Wishbone signals of the serial
//               bus master.
//                 rx_*  : byte stream from the UART receiver
//                 tx_*  : byte stream to the UART transmitter
//                 wbm_* : Wishbone classic-cycle initiator signals
//               modport master : the wb_serial_master side
//               modport slave  : the UART / Wishbone target side
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_serial_master_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  rx_data_i, rx_valid_i,
    output rx_ready_o,
    output tx_data_o, tx_valid_o,
    input  tx_ready_i,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_ack_i, wbm_err_i, wbm_dat_i
  );

  modport slave (
    output rx_data_i, rx_valid_i,
    input  rx_ready_o,
    input  tx_data_o, tx_valid_o,
    output tx_ready_i,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_ack_i, wbm_err_i, wbm_dat_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_serial_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_serial_master
// Description : Byte-stream to Wishbone initiator. Parses command frames
//               (cmd, 4 address bytes, 4 data bytes for writes; MSB first)
//               from the UART receiver, runs one Wishbone classic cycle and
//               answers on the UART transmitter:
//                 'W' 0x57 write -> 0x06 on ack
//                 'R' 0x52 read  -> 4 read-data bytes on ack
//                 bus error, timeout or unknown command -> 0x15
// Ports       : wb_clk_i  - clock (rising edge)
//               wb_rst_ni - asynchronous active-low reset
//               bus       - wb_serial_master_if.master (rx/tx byte streams,
//                           Wishbone master signals)
//               busy_o    - high whenever the FSM is not idle
// Parameters  : TIMEOUT_CYCLES - bus cycles to wait for ack/err
// Config      : define WB_SERIAL_MASTER_TIMEOUT_EN to compile in the bus
//               timeout; without it BUS waits indefinitely for ack/err.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_serial_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  wb_serial_master_if.master bus,
  output logic               busy_o
);

  localparam logic [7:0] c_cmd_write = 8'h57;
  localparam logic [7:0] c_cmd_read  = 8'h52;
  localparam logic [7:0] c_rsp_ok    = 8'h06;
  localparam logic [7:0] c_rsp_nak   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;        // byte index within ADDR/DATA/RESP
  logic        r_write;      // current frame is a write
  logic        r_rd_rsp;     // response is 4 read-data bytes (else 1 byte)
  logic        r_rx_ready;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_tx_shift;   // response bytes, next one in [31:24]

  logic        w_rx_fire;
  logic        w_tx_fire;
  logic        w_tx_last;
  logic        w_cmd_ok;
  logic        w_in_bus;
  logic        w_timeout;

  assign w_in_bus  = (r_state == S_BUS);
  assign w_rx_fire = bus.rx_valid_i & r_rx_ready;
  assign w_tx_fire = (r_state == S_RESP) & bus.tx_ready_i;
  assign w_tx_last = ~r_rd_rsp | (r_cnt == 2'd3);
  assign w_cmd_ok  = (bus.rx_data_i == c_cmd_write) |
                     (bus.rx_data_i == c_cmd_read);

  // --------------------------------------------------------------------------
  // Optional bus timeout
  // --------------------------------------------------------------------------
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
  // Compare against N-1 so cyc is high for exactly TIMEOUT_CYCLES cycles:
  // the counter is 0 in the first BUS cycle.
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  logic [c_tmo_w-1:0] r_tmo_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (!w_in_bus) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = w_in_bus & (r_tmo_cnt == c_tmo_last);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          w_state_nxt = w_cmd_ok ? S_ADDR : S_RESP;
        end
      end
      S_ADDR: begin
        if (w_rx_fire && (r_cnt == 2'd3)) begin
          w_state_nxt = r_write ? S_DATA : S_BUS;
        end
      end
      S_DATA: begin
        if (w_rx_fire && (r_cnt == 2'd3)) begin
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        if (bus.wbm_err_i || bus.wbm_ack_i || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_tx_fire && w_tx_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: frame capture, bus result capture, response shifting
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cnt      <= 2'd0;
      r_write    <= 1'b0;
      r_rd_rsp   <= 1'b0;
      r_rx_ready <= 1'b0;
      r_adr      <= 32'h0;
      r_dat      <= 32'h0;
      r_tx_shift <= 32'h0;
    end else begin
      // Registered so the receiver sees ready low during reset and high
      // from the first edge afterwards.
      r_rx_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ADDR) ||
                    (w_state_nxt == S_DATA);
      case (r_state)
        S_IDLE: begin
          if (w_rx_fire) begin
            r_cnt      <= 2'd0;
            r_write    <= (bus.rx_data_i == c_cmd_write);
            r_rd_rsp   <= 1'b0;
            // Only presented if the command is rejected; a valid command
            // reloads this at the end of the bus cycle.
            r_tx_shift <= {c_rsp_nak, 24'h0};
          end
        end
        S_ADDR: begin
          if (w_rx_fire) begin
            r_adr <= {r_adr[23:0], bus.rx_data_i};
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (w_rx_fire) begin
            r_dat <= {r_dat[23:0], bus.rx_data_i};
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_BUS: begin
          // err beats ack; ack beats a timeout expiring in the same cycle
          if (bus.wbm_err_i) begin
            r_tx_shift <= {c_rsp_nak, 24'h0};
            r_rd_rsp   <= 1'b0;
          end else if (bus.wbm_ack_i) begin
            if (r_write) begin
              r_tx_shift <= {c_rsp_ok, 24'h0};
              r_rd_rsp   <= 1'b0;
            end else begin
              r_tx_shift <= bus.wbm_dat_i;
              r_rd_rsp   <= 1'b1;
            end
          end else if (w_timeout) begin
            r_tx_shift <= {c_rsp_nak, 24'h0};
            r_rd_rsp   <= 1'b0;
          end
        end
        S_RESP: begin
          if (w_tx_fire) begin
            r_tx_shift <= {r_tx_shift[23:0], 8'h00};
            r_cnt      <= r_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.rx_ready_o = r_rx_ready;
  assign bus.tx_valid_o = (r_state == S_RESP);
  assign bus.tx_data_o  = (r_state == S_RESP) ? r_tx_shift[31:24] : 8'h00;
  assign bus.wbm_adr_o  = r_adr;
  assign bus.wbm_dat_o  = r_dat;
  assign bus.wbm_sel_o  = {4{w_in_bus}};
  assign bus.wbm_we_o   = w_in_bus & r_write;
  assign bus.wbm_cyc_o  = w_in_bus;
  assign bus.wbm_stb_o  = w_in_bus;
  assign busy_o         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_serial_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_serial_master
// Description : Self-checking bench for wb_serial_master. A frame-level
//               reference model pushes the expected bus transactions and
//               response bytes into queues; independent monitors pop and
//               compare whenever the DUT runs a bus cycle or hands over a
//               response byte. A small Wishbone slave model answers with a
//               per-frame scripted response (ack/err/both/never + waits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_serial_master;

  localparam int TMO = 16;
  localparam logic [7:0] NAK  = 8'h15;
  localparam logic [7:0] OKB  = 8'h06;
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  typedef struct {
    int          mode;
    int          wt;
    logic [31:0] rdata;
  } slv_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          ncyc;
  } bus_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  wb_serial_master_if bus ();

  wb_serial_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  slv_t        slv_q[$];
  bus_t        bus_q[$];
  logic [7:0]  tx_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          rdy_mode    = 2;   // 0 random, 1 toggle, 2 always ready

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.rx_ready_o, bus.tx_data_o, bus.tx_valid_o, bus.wbm_adr_o,
             bus.wbm_dat_o, bus.wbm_sel_o, bus.wbm_we_o, bus.wbm_cyc_o,
             bus.wbm_stb_o, busy};
  endfunction

  // ---------------------------------------------------------------- slave
  slv_t cur;
  logic have = 1'b0;
  int   wcnt = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      bus.wbm_dat_i = 32'h0;
      have = 1'b0;
      wcnt = 0;
    end else if (bus.wbm_cyc_o && !bus.wbm_ack_i && !bus.wbm_err_i) begin
      if (!have) begin
        if (slv_q.size() > 0) cur = slv_q.pop_front();
        else cur = '{M_ACK, 0, 32'h0};
        have = 1'b1;
        wcnt = 0;
      end
      if (cur.mode != M_NONE && wcnt >= cur.wt) begin
        bus.wbm_ack_i = (cur.mode == M_ACK) || (cur.mode == M_BOTH);
        bus.wbm_err_i = (cur.mode == M_ERR) || (cur.mode == M_BOTH);
        bus.wbm_dat_i = cur.rdata;
      end else begin
        wcnt++;
      end
    end else begin
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      if (!bus.wbm_cyc_o) have = 1'b0;
    end
  end

  // ------------------------------------------------------- tx ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.tx_ready_i = 1'($urandom_range(0, 1));
      1:       bus.tx_ready_i = (bus.tx_ready_i !== 1'b1);
      default: bus.tx_ready_i = 1'b1;
    endcase
  end

  // -------------------------------------------------------------- monitor
  int          bus_cnt    = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h0;
  logic        m_we;
  logic [31:0] m_adr, m_dat;
  bus_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("tx_hold", {bus.tx_valid_o, bus.tx_data_o}, {1'b1, prev_data});
      if (bus.tx_valid_o && bus.tx_ready_i) begin
        if (tx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got %02h, required no byte",
                   bus.tx_data_o);
        end else begin
          check("tx_byte", bus.tx_data_o, tx_q.pop_front());
        end
      end
      prev_stall = bus.tx_valid_o && !bus.tx_ready_i;
      prev_data  = bus.tx_data_o;

      if (bus.wbm_cyc_o) begin
        bus_cnt++;
        m_we  = bus.wbm_we_o;
        m_adr = bus.wbm_adr_o;
        m_dat = bus.wbm_dat_o;
        check("stb_sel", {bus.wbm_stb_o, bus.wbm_sel_o}, {1'b1, 4'hF});
      end else if (bus_cnt > 0) begin
        if (bus_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL bus_unexpected: got adr %08h, required no cycle",
                   m_adr);
        end else begin
          e = bus_q.pop_front();
          check("bus_adr", m_adr, e.adr);
          check("bus_we", m_we, e.we);
          if (e.we) check("bus_dat", m_dat, e.dat);
          check("bus_cyc_len", bus_cnt, e.ncyc);
        end
        bus_cnt = 0;
      end else begin
        check("sel_idle", {bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}, 0);
      end

      if ((bus.wbm_cyc_o || bus.tx_valid_o) && bus.rx_valid_i)
        check("rx_backpressure", bus.rx_ready_o, 1'b0);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic summary_and_fatal(input string why);
    $display("FAIL %s: bound expired, required completion", why);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $fatal(1, "aborted");
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.rx_valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.rx_ready_o) break;
      n++;
      if (n > 5000) summary_and_fatal("rx_accept");
    end
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
  endtask

  // Reference model: one frame in, expected bus cycle and reply bytes out.
  task automatic issue(input logic [7:0] cmd, input logic [31:0] adr,
                       input logic [31:0] dat, input int mode, input int wt,
                       input logic [31:0] rdata, input int gap,
                       input bit expect_done);
    logic [7:0] b[$];
    bus_t       eb;
    logic       is_w, is_r;
    is_w = (cmd == 8'h57);
    is_r = (cmd == 8'h52);
    b.push_back(cmd);
    if (is_w || is_r) begin
      for (int i = 3; i >= 0; i--) b.push_back(8'(adr >> (8 * i)));
      if (is_w)
        for (int i = 3; i >= 0; i--) b.push_back(8'(dat >> (8 * i)));
      slv_q.push_back('{mode, wt, rdata});
      if (expect_done) begin
        eb = '{is_w, adr, dat, (mode == M_NONE) ? TMO : wt + 1};
        bus_q.push_back(eb);
        if (mode != M_ACK)   tx_q.push_back(NAK);
        else if (is_w)       tx_q.push_back(OKB);
        else
          for (int i = 3; i >= 0; i--) tx_q.push_back(8'(rdata >> (8 * i)));
      end
    end else if (expect_done) begin
      tx_q.push_back(NAK);
    end
    foreach (b[i]) send_byte(b[i], (i == 0) ? gap : $urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_q.size() != 0 || bus_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n >= 3000), 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc();
    int n = 0;
    while (!bus.wbm_cyc_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cyc_start_timeout", (n >= 100), 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", any_out(), 1'b0);
    bus.rx_valid_i = 1'b0;
    tx_q.delete();
    bus_q.delete();
    slv_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r, mode, lows;
    logic [7:0] cmd;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    #1;
    check("reset_outputs", any_out(), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rx_ready_before_edge", bus.rx_ready_o, 1'b0);
    @(negedge clk);
    check("rx_ready_after_edge", bus.rx_ready_o, 1'b1);
    @(posedge clk);
    #1;

    // Directed: write with 2 wait states, read with stalled transmitter
    rdy_mode = 2;
    issue(8'h57, 32'h3000_0004, 32'hDEAD_BEEF, M_ACK, 2, 32'h0, 0, 1'b1);
    wait_idle();
    rdy_mode = 1;
    issue(8'h52, 32'h3000_0008, 32'h0, M_ACK, 0, 32'h1234_5678, 0, 1'b1);
    wait_idle();
    rdy_mode = 2;
    issue(8'h57, 32'h0000_0010, 32'h5555_AAAA, M_ERR, 1, 32'h0, 0, 1'b1);
    issue(8'h41, 32'h0, 32'h0, M_ACK, 0, 32'h0, 0, 1'b1);
    issue(8'h52, 32'h0000_0020, 32'h0, M_BOTH, 0, 32'hFFFF_FFFF, 0, 1'b1);
    wait_idle();

    // Slave that never answers
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
    issue(8'h57, 32'h0000_0040, 32'h0BAD_F00D, M_NONE, 0, 32'h0, 0, 1'b1);
    wait_idle();
`else
    issue(8'h57, 32'h0000_0040, 32'h0BAD_F00D, M_NONE, 0, 32'h0, 0, 1'b0);
    wait_cyc();
    lows = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!bus.wbm_cyc_o) lows++;
    end
    check("no_timeout_cyc_low_cycles", lows, 0);
    @(posedge clk);
    #1;
    pulse_reset();
`endif

    // Reset after 3 address bytes, then during BUS
    send_byte(8'h52, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    pulse_reset();
    issue(8'h52, 32'h0000_0080, 32'h0, M_NONE, 0, 32'h0, 0, 1'b0);
    wait_cyc();
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();
    issue(8'h52, 32'h0000_0084, 32'h0, M_ACK, 1, 32'hCAFE_0123, 0, 1'b1);
    wait_idle();

    // Random back-to-back frames (next frame held on rx during BUS/RESP)
    for (int k = 0; k < 40; k++) begin
      rdy_mode = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      cmd = (r < 5) ? 8'h57 : (r < 9) ? 8'h52 : 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      mode = (r < 6) ? M_ACK : (r < 8) ? M_ERR : (r < 9) ? M_BOTH : M_ACK;
`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
      if (r == 9) mode = M_NONE;
`endif
      issue(cmd, $urandom, $urandom, mode, $urandom_range(0, 3), $urandom,
            ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b1);
    end
    wait_idle();
    check("leftover_expectations", tx_q.size() + bus_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
`default_nettype wire
